// File: rtl/decode_stage_pkg.sv
// ============================================================================
// Module      : decode_stage_pkg
// Description : Opcode constants, IR field positions and immediate-extension
//               helpers shared by the decode stage and the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RD_MSB     = 20;
    localparam int RD_LSB     = 16;
    localparam int RT_MSB     = 15;
    localparam int RT_LSB     = 11;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'd0,
        EXT_ZERO   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_e;

    // Opcodes without a dedicated rule (R-type included) fall back to sign-extension.
    function automatic ext_mode_e ext_mode(input logic [5:0] opcode);
        case (opcode)
            OP_ANDI, OP_ORI:       return EXT_ZERO;
            OP_LUI:                return EXT_UPPER;
            OP_B, OP_BEQ, OP_BNE:  return EXT_BRANCH;
            default:               return EXT_SIGN;
        endcase
    endfunction

    function automatic logic [31:0] extend_imm(input logic [5:0] opcode,
                                               input logic [15:0] imm16);
        case (ext_mode(opcode))
            EXT_ZERO:   return {16'h0000, imm16};
            EXT_UPPER:  return {imm16, 16'h0000};
            EXT_BRANCH: return {{14{imm16[15]}}, imm16, 2'b00};
            default:    return {{16{imm16[15]}}, imm16};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_if.sv
// ============================================================================
// Module      : decode_stage_if
// Description : Control/datapath bundle between the control FSM and the
//               decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_stage_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       Instr;
    logic              IR_LdEn;
    logic              RF_WrEn;
    logic              RF_WrData_Sel;
    logic              RF_B_Sel;
    logic [DATA_W-1:0] ALU_Out;
    logic [DATA_W-1:0] MEM_Out;
    logic [5:0]        Opcode;
    logic [5:0]        Func;
    logic [DATA_W-1:0] RF_A;
    logic [DATA_W-1:0] RF_B;
    logic [31:0]       Immed;

    modport master (
        output Instr, IR_LdEn, RF_WrEn, RF_WrData_Sel, RF_B_Sel, ALU_Out, MEM_Out,
        input  Opcode, Func, RF_A, RF_B, Immed
    );

    modport slave (
        input  Instr, IR_LdEn, RF_WrEn, RF_WrData_Sel, RF_B_Sel, ALU_Out, MEM_Out,
        output Opcode, Func, RF_A, RF_B, Immed
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage_register_file.sv
// ============================================================================
// Module      : register_file
// Description : Register array with two asynchronous read ports, one
//               synchronous write port and a hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [ADDR_W-1:0] addr_a,
    input  wire logic [ADDR_W-1:0] addr_b,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [DATA_W-1:0] wr_data,
    output logic      [DATA_W-1:0] data_a,
    output logic      [DATA_W-1:0] data_b
);

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Address zero is forced on the read side so R0 never depends on array contents.
    assign data_a = (addr_a == '0) ? '0 : regs[addr_a];
    assign data_b = (addr_b == '0) ? '0 : regs[addr_b];

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Instruction register, register-file read/write-back and
//               immediate extension for the multi-cycle datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    decode_stage_if.slave bus
);

    localparam int ADDR_W = $clog2(RF_DEPTH);

    logic [31:0]       ir;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] wr_data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ir <= '0;
        end else if (bus.IR_LdEn) begin
            ir <= bus.Instr;
        end
    end

    assign rs      = ir[RS_MSB:RS_LSB];
    assign rd      = ir[RD_MSB:RD_LSB];
    assign rt      = ir[RT_MSB:RT_LSB];
    assign b_addr  = bus.RF_B_Sel ? rd : rt;
    assign wr_data = bus.RF_WrData_Sel ? bus.MEM_Out : bus.ALU_Out;

    // rd comes from the registered IR, so a write coinciding with an IR load
    // lands in the register named by the outgoing instruction.
    register_file #(
        .DATA_W (DATA_W),
        .DEPTH  (RF_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_register_file (
        .clk     (Clk),
        .rst     (Reset),
        .addr_a  (rs),
        .addr_b  (b_addr),
        .wr_en   (bus.RF_WrEn),
        .wr_addr (rd),
        .wr_data (wr_data),
        .data_a  (bus.RF_A),
        .data_b  (bus.RF_B)
    );

    assign bus.Opcode = ir[OPCODE_MSB:OPCODE_LSB];
    assign bus.Func   = ir[FUNC_MSB:FUNC_LSB];
    assign bus.Immed  = extend_imm(ir[OPCODE_MSB:OPCODE_LSB], ir[IMM_MSB:IMM_LSB]);

    wire unused_ir_bits = ^ir[10:6];

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed vector table plus hand-written multi-cycle sequences
//               for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    decode_stage_if #(.DATA_W(32)) bus ();

    decode_stage #(
        .DATA_W   (32),
        .RF_DEPTH (32)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] instr;
        logic        ld;
        logic        wr;
        logic        wsel;
        logic        bsel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs, rd, imm};
    endfunction

    function automatic vec_t v(input logic [31:0] instr, input logic ld, input logic wr,
                               input logic wsel, input logic bsel,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm);
        vec_t r;
        r.instr = instr; r.ld = ld; r.wr = wr; r.wsel = wsel; r.bsel = bsel;
        r.alu = alu; r.mem = mem; r.op = op; r.fn = fn; r.a = a; r.b = b; r.imm = imm;
        return r;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic ld, input logic wr,
                         input logic wsel, input logic bsel,
                         input logic [31:0] alu, input logic [31:0] mem);
        bus.Instr         = instr;
        bus.IR_LdEn       = ld;
        bus.RF_WrEn       = wr;
        bus.RF_WrData_Sel = wsel;
        bus.RF_B_Sel      = bsel;
        bus.ALU_Out       = alu;
        bus.MEM_Out       = mem;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm);
        check({tag, ".opcode"}, {26'd0, bus.Opcode}, {26'd0, op});
        check({tag, ".func"},   {26'd0, bus.Func},   {26'd0, fn});
        check({tag, ".rf_a"},   bus.RF_A,            a);
        check({tag, ".rf_b"},   bus.RF_B,            b);
        check({tag, ".immed"},  bus.Immed,           imm);
    endtask

    initial begin
        // Register state is tracked by hand down the table; R3 ends at 0x42, R7=7, R9=9.
        tbl[0]  = v(mk(6'b110000, 0, 3, 16'h8004), 1, 0, 0, 0, 0, 0,
                    6'h30, 6'h04, 32'h0, 32'h0, 32'hFFFF8004);
        tbl[1]  = v(32'h0, 0, 1, 0, 1, 32'hDEADBEEF, 32'h0,
                    6'h30, 6'h04, 32'h0, 32'hDEADBEEF, 32'hFFFF8004);
        tbl[2]  = v(32'h0, 0, 1, 1, 1, 32'h0, 32'h42,
                    6'h30, 6'h04, 32'h0, 32'h42, 32'hFFFF8004);
        tbl[3]  = v(mk(6'b110011, 3, 0, 16'h8004), 1, 0, 0, 0, 0, 0,
                    6'h33, 6'h04, 32'h42, 32'h0, 32'h00008004);
        tbl[4]  = v(32'h0, 0, 1, 0, 1, 32'hFFFFFFFF, 32'h0,
                    6'h33, 6'h04, 32'h42, 32'h0, 32'h00008004);
        tbl[5]  = v(mk(6'b111001, 0, 0, 16'h8004), 1, 0, 0, 0, 0, 0,
                    6'h39, 6'h04, 32'h0, 32'h0, 32'h80040000);
        tbl[6]  = v(mk(6'b000000, 3, 3, 16'h8004), 1, 0, 0, 1, 0, 0,
                    6'h00, 6'h04, 32'h42, 32'h42, 32'hFFFE0010);
        tbl[7]  = v(mk(6'b111000, 0, 7, 16'h4800), 1, 0, 0, 0, 0, 0,
                    6'h38, 6'h00, 32'h0, 32'h0, 32'h00004800);
        tbl[8]  = v(32'h0, 0, 1, 0, 1, 32'h7, 32'h0,
                    6'h38, 6'h00, 32'h0, 32'h7, 32'h00004800);
        tbl[9]  = v(mk(6'b111000, 0, 9, 16'h0009), 1, 0, 0, 1, 0, 0,
                    6'h38, 6'h09, 32'h0, 32'h0, 32'h00000009);
        tbl[10] = v(32'h0, 0, 1, 0, 1, 32'h9, 32'h0,
                    6'h38, 6'h09, 32'h0, 32'h9, 32'h00000009);
        tbl[11] = v(mk(6'b110010, 9, 7, 16'h4ABC), 1, 0, 0, 0, 0, 0,
                    6'h32, 6'h3C, 32'h9, 32'h9, 32'h00004ABC);
        tbl[12] = v(32'h0, 0, 0, 0, 1, 32'h0, 32'h0,
                    6'h32, 6'h3C, 32'h9, 32'h7, 32'h00004ABC);
        tbl[13] = v(mk(6'b000001, 7, 0, 16'hFFFF), 1, 0, 0, 0, 0, 0,
                    6'h01, 6'h3F, 32'h7, 32'h0, 32'hFFFFFFFC);
        tbl[14] = v(mk(6'b111111, 0, 0, 16'h0001), 1, 0, 0, 0, 0, 0,
                    6'h3F, 6'h01, 32'h0, 32'h0, 32'h00000004);
        tbl[15] = v(mk(6'b001111, 9, 0, 16'h8000), 1, 0, 0, 0, 0, 0,
                    6'h0F, 6'h00, 32'h9, 32'h0, 32'hFFFF8000);

        Reset = 1'b1;
        drive(32'hFFFFFFFF, 1, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        check_all("reset_init", 6'h00, 6'h00, 32'h0, 32'h0, 32'h0);
        Reset = 1'b0;
        drive(32'h0, 0, 0, 0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].instr, tbl[i].ld, tbl[i].wr, tbl[i].wsel, tbl[i].bsel,
                  tbl[i].alu, tbl[i].mem);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b,
                      tbl[i].imm);
        end

        // Write to the register being read: old value until the edge, new value after.
        drive(mk(6'b110000, 3, 3, 16'h0000), 1, 0, 0, 0, 0, 0);
        tick();
        drive(32'h0, 0, 1, 0, 0, 32'h77, 32'h0);
        #1;
        check("raw_before_edge", bus.RF_A, 32'h42);
        tick();
        check("raw_after_edge", bus.RF_A, 32'h77);
        drive(32'h0, 0, 0, 0, 0, 0, 0);

        // IR load and write in one cycle: the write targets the outgoing rd.
        drive(mk(6'b110000, 0, 4, 16'h0000), 1, 0, 0, 0, 0, 0);
        tick();
        drive(mk(6'b110000, 4, 6, 16'h0000), 1, 1, 0, 1, 32'h55, 32'h0);
        tick();
        check("simul_r4", bus.RF_A, 32'h55);
        check("simul_r6", bus.RF_B, 32'h0);
        drive(32'h0, 0, 0, 0, 0, 0, 0);

        // Mid-operation reset with load and write both asserted.
        drive(mk(6'b110000, 5, 5, 16'h0000), 1, 0, 0, 0, 0, 0);
        tick();
        drive(32'h0, 0, 1, 0, 0, 32'h1234, 32'h0);
        tick();
        check("r5_written", bus.RF_A, 32'h1234);
        Reset = 1'b1;
        drive(mk(6'b110000, 5, 5, 16'h0001), 1, 1, 0, 0, 32'hFFFF, 32'h0);
        tick();
        check_all("reset_mid", 6'h00, 6'h00, 32'h0, 32'h0, 32'h0);
        Reset = 1'b0;
        drive(mk(6'b110000, 5, 3, 16'h0000), 1, 0, 0, 1, 0, 0);
        tick();
        check("r5_cleared", bus.RF_A, 32'h0);
        check("r3_cleared", bus.RF_B, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
